// File: rtl/pixel_stream_fifo_pkg.sv
// Shared types and constants for the pixel stream FIFO in front of the HDMI output stage.
package pixel_stream_fifo_pkg;

    typedef enum logic {
        SYNC,
        ACTIVE
    } state_t;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    localparam rgb_t UNDERFLOW_RGB_DEFAULT = 24'hFF00FF;

endpackage

// File: rtl/pixel_stream_fifo_if.sv
// Valid/ready pixel stream from the producer into the FIFO.
interface pixel_stream_fifo_if;
    import pixel_stream_fifo_pkg::*;

    logic s_valid;
    logic s_ready;
    rgb_t s_data;
    logic s_sof;

    modport master (output s_valid, output s_data, output s_sof, input s_ready);
    modport slave  (input s_valid, input s_data, input s_sof, output s_ready);

endinterface

// File: rtl/pixel_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; head is read combinationally from mem[rd_ptr].
module pixel_fifo_fwft #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 25,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic [WIDTH-1:0] head
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_stream_fifo.sv
// Buffers producer pixels and feeds the HDMI raster with zero latency, aligning sof to frame start.
module pixel_stream_fifo
    import pixel_stream_fifo_pkg::*;
#(
    parameter int unsigned DEPTH         = 1024,
    parameter rgb_t        UNDERFLOW_RGB = UNDERFLOW_RGB_DEFAULT
) (
    input  logic                  clk_pixel,
    input  logic                  rst,
    pixel_stream_fifo_if.slave    s,
    input  logic                  i_enable,
    input  logic                  i_newline,
    input  logic                  i_newframe,
    output logic [7:0]            o_red,
    output logic [7:0]            o_green,
    output logic [7:0]            o_blue,
    output logic                  o_locked,
    output logic                  o_underflow,
    output logic                  o_misalign,
    output logic [$clog2(DEPTH):0] o_level
);

    state_t state, next_state;
    logic   first, next_first;
    logic   pop;
    logic   set_underflow, set_misalign;
    rgb_t   pix;
    logic   full, empty;
    logic   head_valid, head_sof;
    rgb_t   head_rgb;
    logic [11:0] line_cnt;

    pixel_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (25)
    ) u_fifo (
        .clk   (clk_pixel),
        .rst_n (rst),
        .push  (s.s_valid),
        .pop   (pop),
        .wdata ({s.s_sof, s.s_data}),
        .full  (full),
        .empty (empty),
        .count (o_level),
        .head  ({head_sof, head_rgb})
    );

    assign s.s_ready  = !full;
    assign head_valid = !empty;
    assign o_locked   = (state == ACTIVE);
    assign o_red      = pix.red;
    assign o_green    = pix.green;
    assign o_blue     = pix.blue;

    always_comb begin
        next_state    = state;
        next_first    = first;
        pop           = 1'b0;
        pix           = '0;
        set_underflow = 1'b0;
        set_misalign  = 1'b0;
        case (state)
            SYNC: begin
                if (head_valid && !head_sof) begin
                    pop = 1'b1;
                end else if (head_valid && i_newframe) begin
                    next_state = ACTIVE;
                    next_first = 1'b1;
                end
            end
            ACTIVE: begin
                if (i_enable) begin
                    if (!head_valid) begin
                        pix           = UNDERFLOW_RGB;
                        set_underflow = 1'b1;
                        next_state    = SYNC;
                    end else if (first != head_sof) begin
                        set_misalign = 1'b1;
                        next_state   = SYNC;
                    end else begin
                        pix        = head_rgb;
                        pop        = 1'b1;
                        next_first = 1'b0;
                    end
                end
                // Frame boundary re-arms the sof expectation unless we just dropped lock.
                if (i_newframe && next_state == ACTIVE) begin
                    next_first = 1'b1;
                end
            end
            default: next_state = SYNC;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge rst) begin
        if (!rst) begin
            state       <= SYNC;
            first       <= 1'b0;
            o_underflow <= 1'b0;
            o_misalign  <= 1'b0;
        end else begin
            state <= next_state;
            first <= next_first;
            if (set_underflow) o_underflow <= 1'b1;
            if (set_misalign)  o_misalign  <= 1'b1;
        end
    end

    always_ff @(posedge clk_pixel or negedge rst) begin
        if (!rst) begin
            line_cnt <= '0;
        end else if (i_newframe) begin
            line_cnt <= '0;
        end else if (state == ACTIVE && i_newline) begin
            line_cnt <= line_cnt + 1'b1;
        end
    end

endmodule

// File: doc/pixel_stream_fifo.md
# pixel_stream_fifo

Upstream pixel source for the HDMI output stage. It buffers RGB pixels from a valid/ready producer in a first-word-fall-through FIFO and presents one pixel per active display cycle on the HDMI stage's colour inputs. It aligns the producer's start-of-frame marker to the display raster and recovers automatically from underflow or misalignment. It runs entirely in the pixel clock domain and is driven by the HDMI stage's enable, newline and newframe strobes.

## Interface
- DEPTH, 1024: FIFO entries, power of two, ≥ 2.
- UNDERFLOW_RGB, 24'hFF00FF: colour driven on the pixel where underflow is detected.
- clk_pixel  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- s_valid  in  1  producer word valid
- s_ready  out  1  FIFO can accept a word
- s_data  in  24  {red, green, blue}, 8 bits each
- s_sof  in  1  word is the first pixel of a frame
- i_enable  in  1  display wants a pixel this cycle (HDMI o_enable)
- i_newline  in  1  last active pixel of line (informational; counted only)
- i_newframe  in  1  last active pixel of frame
- o_red, o_green, o_blue  out  8 each  pixel for current cycle
- o_locked  out  1  state is ACTIVE
- o_underflow  out  1  sticky: display starved
- o_misalign  out  1  sticky: sof not at frame start
- o_level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Storage: each entry is 25 bits, {sof, rgb}. Read and write pointers are $clog2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH)+1 bits.
- Push when s_valid && s_ready. s_ready = (count != DEPTH). Push and pop in the same cycle are allowed; count is unchanged.
- When full, s_ready stays low even if a pop occurs that cycle.
- Head (head_valid = count != 0, head_sof, head_rgb) is combinational from mem[rd_ptr].
- States:
  - SYNC (reset state):
    - If head_valid && !head_sof: pop (discard).
    - Else if head_valid && head_sof && i_newframe: go to ACTIVE and set first=1. No pop.
    - i_enable never pops in SYNC. Discard takes priority over i_newframe in the same cycle.
  - ACTIVE, on cycles with i_enable=1, priority in this order:
    1. !head_valid: drive UNDERFLOW_RGB, set o_underflow, go to SYNC.
    2. first && !head_sof: drive 0, set o_misalign, go to SYNC, no pop.
    3. !first && head_sof: drive 0, set o_misalign, go to SYNC, no pop.
    4. Otherwise: drive head_rgb, pop, clear first.
  - ACTIVE with i_newframe=1: the current pixel is processed per the rules above, then first is set to 1. A transition to SYNC overrides this.
  - ACTIVE with i_enable=0: drive 0, no pop.
- RGB outputs are 0 whenever no pixel is being delivered.
- Sticky flags clear only on reset.
- An internal line counter (increments on i_newline in ACTIVE, clears on i_newframe) is provided for debug. It is not a port.

## Timing
- Reset values: s_ready=1 (async reset drives count to 0), o_red/o_green/o_blue=0, o_locked=0, o_underflow=0, o_misalign=0, o_level=0, state SYNC, both pointers 0.
- A word pushed at edge t is head-visible and counted in o_level from cycle t+1.
- The pixel output is combinational from the head in the same cycle as i_enable. It has zero latency relative to the raster, which the HDMI stage requires.
- Pop, state update and flag updates take effect at the clock edge ending that cycle.
- Lock latency: the first sof-aligned frame displays on the raster frame after the i_newframe that found sof at the head.
- Reset asserted mid-frame: FIFO contents are discarded (pointers reset) and the block returns to SYNC immediately.

## Structure
- A shared package holds:
  - the state enum (SYNC, ACTIVE)
  - the 24-bit rgb_t typedef with red/green/blue fields
  - a default UNDERFLOW_RGB constant
- One sub-module: pixel_fifo_fwft, a parameterised synchronous FWFT FIFO. It has push/pop, full/empty and count, and a combinational head.
- The state machine, first flag and sticky flags live in the top level.

## Test plan
- Reset mid-stream: 100 words queued, rst low for 1 cycle → o_level=0, outputs 0, o_locked=0, s_ready=1.
- Lock and stream: push 307200 pixels with sof on word 0 and rgb = pixel index; drive the 640×480 raster (800×525 totals) → o_locked rises after the first i_newframe, and the next frame outputs index 0..307199 in order with no flags set.
- Garbage before sof: push 5 non-sof words, then a sof frame → the 5 words are discarded at 1 per cycle, and the lock then proceeds as above.
- Underflow: lock, then supply only 1000 pixels → pixel 1000 shows FF00FF, o_underflow=1, state returns to SYNC, and the block relocks on the next supplied sof frame.
- Misalignment: push a frame with sof on word 0 and a second sof at word 500 → at pixel 500 the output is 0, o_misalign=1, and the block returns to SYNC. The sof word is retained and relocks at the next i_newframe.
- Full FIFO: DEPTH=16, producer always valid, display idle → o_level reaches 16, s_ready=0, and simultaneous push+pop at full is not accepted.
